// File: rtl/dtcm_icb_ctrl_pkg.sv
// Shared types and constants for the DTCM ICB slave controller.
package dtcm_icb_ctrl_pkg;

    localparam logic [3:0] DTCM_ADDR_HEAD = 4'b0011;
    localparam int         ICB_DW         = 64;
    localparam int         ICB_MW         = 8;
    localparam int         RSP_W          = ICB_DW + 1;

    typedef struct packed {
        logic [ICB_DW-1:0] rdata;
        logic              err;
    } dtcm_rsp_t;

endpackage

// File: rtl/dtcm_rsp_fifo.sv
// Two-entry response FIFO; pointers/count reset, data storage left unreset.
module dtcm_rsp_fifo
    import dtcm_icb_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [RSP_W-1:0] i_din,
    input  logic             i_pop,
    output logic [RSP_W-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [1:0]       o_cnt
);

    logic [RSP_W-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);
    assign o_cnt   = r_cnt;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(i_push && r_cnt == 2'd2));

endmodule

// File: rtl/dtcm_icb_ctrl.sv
// DTCM ICB slave: drives a 1-cycle-latency SRAM, in-order responses via 2-entry buffer.
// Optional out-of-window error checking is enabled by defining DTCM_ADDR_CHK_EN.
module dtcm_icb_ctrl
    import dtcm_icb_ctrl_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 64,
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [AW-1:0]     icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [DW-1:0]     icb_cmd_wdata,
    input  logic [7:0]        icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [DW-1:0]     icb_rsp_rdata,
    output logic              icb_rsp_err,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [7:0]        ram_wem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    logic             w_acc;
    logic             w_cmd_err;
    logic             w_unused_addr;
    logic             r_s1_vld;
    logic             r_s1_read;
    logic             r_s1_err;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [1:0]       w_fifo_cnt;
    logic [RSP_W-1:0] w_fifo_dout;
    dtcm_rsp_t        w_s1_rsp;
    dtcm_rsp_t        w_rsp;

`ifdef DTCM_ADDR_CHK_EN
    assign w_cmd_err = (icb_cmd_addr[AW-1:AW-4] != DTCM_ADDR_HEAD)
                     | (|icb_cmd_addr[AW-5:RAM_AW+3]);
`else
    assign w_cmd_err = 1'b0;
`endif
    assign w_unused_addr = ^{icb_cmd_addr[2:0], icb_cmd_addr[AW-1:RAM_AW+3]};

    // Credit check: ready = (cnt + s1_vld) < 2, expressed via full/cnt.
    assign icb_cmd_ready = !w_fifo_full && !(w_fifo_cnt == 2'd1 && r_s1_vld);
    assign w_acc         = icb_cmd_valid && icb_cmd_ready;

    assign ram_cs   = w_acc && !w_cmd_err;
    assign ram_we   = ram_cs && !icb_cmd_read;
    assign ram_wem  = ram_we ? icb_cmd_wmask : '0;
    assign ram_addr = icb_cmd_addr[RAM_AW+2:3];
    assign ram_din  = icb_cmd_wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld  <= 1'b0;
            r_s1_read <= 1'b0;
            r_s1_err  <= 1'b0;
        end else begin
            r_s1_vld  <= w_acc;
            r_s1_read <= w_acc && icb_cmd_read;
            r_s1_err  <= w_acc && w_cmd_err;
        end
    end

    always_comb begin
        w_s1_rsp.err   = r_s1_err;
        w_s1_rsp.rdata = (r_s1_read && !r_s1_err) ? ram_dout : '0;
    end

    // The SRAM output is only valid in the s1 cycle, so s1 is captured unless it leaves via bypass.
    assign w_push = r_s1_vld && (!w_fifo_empty || !icb_rsp_ready);
    assign w_pop  = !w_fifo_empty && icb_rsp_ready;

    dtcm_rsp_fifo u_rsp_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_din   (w_s1_rsp),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_cnt   (w_fifo_cnt)
    );

    always_comb begin
        w_rsp = '0;
        if (!w_fifo_empty) w_rsp = w_fifo_dout;
        else if (r_s1_vld) w_rsp = w_s1_rsp;
    end

    assign icb_rsp_valid = !w_fifo_empty || r_s1_vld;
    assign icb_rsp_rdata = w_rsp.rdata;
    assign icb_rsp_err   = w_rsp.err;

endmodule

// File: tb/tb_dtcm_icb_ctrl.sv
// Scoreboard bench for dtcm_icb_ctrl with a behavioural 1-cycle SRAM model.
module tb_dtcm_icb_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0] icb_cmd_addr;
    logic [63:0] icb_cmd_wdata;
    logic [7:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [63:0] icb_rsp_rdata;
    logic        ram_cs, ram_we;
    logic [7:0]  ram_wem;
    logic [11:0] ram_addr;
    logic [63:0] ram_din, ram_dout;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] mem [4096];

    localparam logic [63:0] W0 = 64'h0102_0304_05AB_0708;

    dtcm_icb_ctrl #(.AW(32), .DW(64), .RAM_AW(12)) dut (
        .clk(clk), .rstn(rstn),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 8; b++)
                    if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic [31:0] a, input logic rd, input logic [63:0] wd,
                             input logic [7:0] wm);
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = a;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
    endtask

    task automatic idle();
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic rd, input logic [63:0] wd,
                         input logic [7:0] wm, input logic [63:0] exp_rdata, input logic exp_err,
                         output logic cs, output logic we, output logic [7:0] wem,
                         output logic [11:0] ra);
        int n = 0;
        exp_t e;
        drive_cmd(a, rd, wd, wm);
        @(negedge clk);
        while (!icb_cmd_ready && n < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        cs = ram_cs; we = ram_we; wem = ram_wem; ra = ram_addr;
        if (!icb_cmd_ready) begin
            chk("accept_timeout", icb_cmd_ready, 1);
        end else begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && icb_rsp_valid && icb_rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual=rdata:%h err:%b required=no response",
                             icb_rsp_rdata, icb_rsp_err);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", icb_rsp_rdata, e.rdata);
                    chk("rsp_err", {63'd0, icb_rsp_err}, {63'd0, e.err});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic        cs, we;
        logic [7:0]  wem;
        logic [11:0] ra;
        int          n;
        exp_t        e;

        for (int i = 0; i < 4096; i++) mem[i] = '0;
        idle();
        icb_cmd_addr  = '0;
        icb_rsp_ready = 1'b1;

        #12;
        chk("rst_rsp_valid", icb_rsp_valid, 0);
        chk("rst_rsp_err", icb_rsp_err, 0);
        chk("rst_rsp_rdata", icb_rsp_rdata, 0);
        chk("rst_cmd_ready", icb_cmd_ready, 1);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wem", ram_wem, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Full write then read-back, checking SRAM strobes and N+1 latency
        issue(32'h3000_0010, 1'b0, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0, cs, we, wem, ra);
        chk("wr_ram_cs", cs, 1);
        chk("wr_ram_we", we, 1);
        chk("wr_ram_wem", wem, 8'hFF);
        chk("wr_ram_addr", ra, 12'd2);
        idle();
        @(negedge clk);
        chk("wr_rsp_latency", icb_rsp_valid, 1);
        @(posedge clk); #1;
        issue(32'h3000_0010, 1'b1, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0, cs, we, wem, ra);
        chk("rd_ram_cs", cs, 1);
        chk("rd_ram_we", we, 0);
        chk("rd_ram_wem", wem, 0);
        idle();
        @(negedge clk);
        chk("rd_rsp_latency", icb_rsp_valid, 1);
        chk("rd_rsp_rdata_direct", icb_rsp_rdata, 64'h1122_3344_5566_7788);
        @(posedge clk); #1;

        // Single-byte store into a fully written word
        issue(32'h3000_0000, 1'b0, 64'h0102_0304_0506_0708, 8'hFF, 64'd0, 1'b0, cs, we, wem, ra);
        issue(32'h3000_0000, 1'b0, {8{8'hAB}}, 8'h04, 64'd0, 1'b0, cs, we, wem, ra);
        chk("sb_ram_wem", wem, 8'h04);
        chk("sb_ram_we", we, 1);
        issue(32'h3000_0000, 1'b1, 64'd0, 8'h00, W0, 1'b0, cs, we, wem, ra);
        idle();
        @(posedge clk); #1;

        for (int k = 1; k < 8; k++)
            issue(32'h3000_0000 + 32'(8 * k), 1'b0, 64'hA5A5_0000_0000_0000 | 64'(k), 8'hFF,
                  64'd0, 1'b0, cs, we, wem, ra);
        idle();
        @(posedge clk); #1;

        // Back-to-back reads: ready held high, one response per cycle
        for (int k = 0; k < 8; k++) begin
            drive_cmd(32'h3000_0000 + 32'(8 * k), 1'b1, 64'd0, 8'h00);
            @(negedge clk);
            chk("burst_cmd_ready", icb_cmd_ready, 1);
            chk("burst_rsp_valid", icb_rsp_valid, {63'd0, k != 0});
            e.rdata = (k == 0) ? W0 : (64'hA5A5_0000_0000_0000 | 64'(k));
            e.err   = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        idle();
        @(negedge clk);
        chk("burst_last_rsp", icb_rsp_valid, 1);
        @(posedge clk); #1;

        // Backpressure: two accepted, third waits until the buffer drains
        icb_rsp_ready = 1'b0;
        issue(32'h3000_0008, 1'b1, 64'd0, 8'h00, 64'hA5A5_0000_0000_0001, 1'b0, cs, we, wem, ra);
        issue(32'h3000_0018, 1'b1, 64'd0, 8'h00, 64'hA5A5_0000_0000_0003, 1'b0, cs, we, wem, ra);
        fork
            issue(32'h3000_0020, 1'b1, 64'd0, 8'h00, 64'hA5A5_0000_0000_0004, 1'b0,
                  cs, we, wem, ra);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_cmd_ready", icb_cmd_ready, 0);
                    chk("bp_rsp_valid", icb_rsp_valid, 1);
                    chk("bp_rsp_head", icb_rsp_rdata, 64'hA5A5_0000_0000_0001);
                end
                @(posedge clk); #1 icb_rsp_ready = 1'b1;
            end
        join
        idle();
        repeat (4) @(posedge clk);
        #1;

        // Out-of-window address: error when checking is built in, alias to word 0 otherwise
`ifdef DTCM_ADDR_CHK_EN
        issue(32'h3010_0000, 1'b1, 64'd0, 8'h00, 64'd0, 1'b1, cs, we, wem, ra);
        chk("oow_ram_cs", cs, 0);
`else
        issue(32'h3010_0000, 1'b1, 64'd0, 8'h00, W0, 1'b0, cs, we, wem, ra);
        chk("oow_ram_cs", cs, 1);
`endif
        chk("oow_ram_addr", ra, 12'd0);
        idle();
        @(posedge clk); #1;

        // Reset with two responses queued drops them
        icb_rsp_ready = 1'b0;
        issue(32'h3000_0008, 1'b1, 64'd0, 8'h00, 64'hA5A5_0000_0000_0001, 1'b0, cs, we, wem, ra);
        issue(32'h3000_0018, 1'b1, 64'd0, 8'h00, 64'hA5A5_0000_0000_0003, 1'b0, cs, we, wem, ra);
        idle();
        @(posedge clk); #1;
        chk("full_cmd_ready", icb_cmd_ready, 0);
        chk("full_rsp_valid", icb_rsp_valid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_rsp_valid", icb_rsp_valid, 0);
        chk("midrst_cmd_ready", icb_cmd_ready, 1);
        chk("midrst_rsp_rdata", icb_rsp_rdata, 0);
        sb.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        icb_rsp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("postrst_no_rsp", icb_rsp_valid, 0);
        end
        @(posedge clk); #1;
        issue(32'h3000_0000, 1'b1, 64'd0, 8'h00, W0, 1'b0, cs, we, wem, ra);
        idle();

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("sb_drained", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
